// File: rtl/wb_uart_tx_if.sv
// Wishbone pipelined byte-write bus between the FIFO controller (master) and
// the UART transmitter (slave).
interface wb_uart_tx_if;
    logic       cyc_i;
    logic       stb_i;
    logic [7:0] dat_i;
    logic       stall_o;
    logic       ack_o;

    modport master (output cyc_i, stb_i, dat_i, input stall_o, ack_o);
    modport slave  (input cyc_i, stb_i, dat_i, output stall_o, ack_o);
endinterface

// File: rtl/wb_uart_tx.sv
// Wishbone pipelined device that serialises one accepted byte as an 8N1 UART
// frame on tx_o, stalling the bus while a frame is in flight.
module wb_uart_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    wb_uart_tx_if.slave wb,
    output logic        tx_o,
    output logic        busy_o
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          ack_q, ack_d;

    logic request;
    logic busy;
    logic accept;
    logic bit_done;

    assign request    = wb.cyc_i && wb.stb_i;
    assign busy       = (state_q != IDLE);
    assign accept     = request && !busy;
    assign bit_done   = (cnt_q == CNT_LAST);
    assign wb.stall_o = request && busy;
    assign wb.ack_o   = ack_q;
    assign tx_o       = tx_q;
    assign busy_o     = busy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        ack_d   = 1'b0;
        tx_d    = 1'b1;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (accept) begin
                    shift_d = wb.dat_i;
                    state_d = START;
                    ack_d   = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is derived from the next state so the line changes exactly on bit boundaries
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ack_q   <= ack_d;
        end
    end

    stall_needs_request: assert property (@(posedge clk_i) wb.stall_o |-> request);
    ack_follows_accept: assert property (@(posedge clk_i) disable iff (rst_i)
        wb.ack_o |-> $past(accept));
    idle_line_high: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == IDLE) |-> tx_q);
    counter_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
        int'(cnt_q) < CLKS_PER_BIT);
endmodule

// File: doc/wb_uart_tx.md
Name: wb_uart_tx

Overview:
Wishbone pipelined device that accepts one byte per transaction and serialises it as an 8N1 UART frame on tx_o. It is the downstream responder for the byte FIFO's Wishbone controller port: FIFO output is wired to this block's device port, and tx_o goes off-chip. It stalls the controller while a frame is in flight, so the FIFO holds data until the transmitter is free.

Parameters:
CLKS_PER_BIT, 4, clk_i cycles per UART bit; legal range >= 2; bit counter width is $clog2(CLKS_PER_BIT).

Ports:
clk_i  input  1  system clock (Wishbone SYSCON clock)
rst_i  input  1  synchronous active-high reset (Wishbone SYSCON reset)
cyc_i  input  1  Wishbone cycle valid
stb_i  input  1  Wishbone strobe
dat_i  input  8  byte to transmit
stall_o  output  1  Wishbone stall
ack_o  output  1  Wishbone acknowledge
tx_o  output  1  UART serial output, idle high
busy_o  output  1  high while a frame is in progress

Behaviour:
- One clock domain, clk_i; reset is synchronous and active-high on rst_i; all state updates on posedge clk_i.
- Reset values: state=IDLE, tx_o=1, ack_o=0, busy_o=0, bit counter=0, bit index=0, shift register=0.
- request = cyc_i && stb_i. stb_i without cyc_i is ignored.
- stall_o = request && busy, combinational. busy = (state != IDLE).
- accept = request && !busy. Only legal in IDLE.
- ack_o is registered. It is 1 in the cycle after accept and 0 otherwise. There is exactly one ack per accepted byte, and no ack is issued for stalled cycles.
- On accept, dat_i is latched into the shift register and state goes to START.
- FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: tx_o=1.
  - START: tx_o=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles; bit index runs 0..7.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles, then IDLE.
- tx_o is registered and glitch-free. The start bit appears in the cycle after accept.
- Bit counter counts 0..CLKS_PER_BIT-1 and wraps on bit completion. State or bit index advances when the counter reaches CLKS_PER_BIT-1.
- Timing: if accept is in cycle N, the frame occupies cycles N+1 .. N+10*CLKS_PER_BIT. busy_o goes high from N+1 and low in cycle N+1+10*CLKS_PER_BIT.
- Back-to-back: the earliest next accept is cycle N+1+10*CLKS_PER_BIT, so the stop bit is effectively CLKS_PER_BIT+1 cycles between frames. The transaction period is 10*CLKS_PER_BIT+1.
- A request arriving in the same cycle the FSM returns to IDLE is accepted in that cycle.
- Deasserting cyc_i mid-frame does not abort the frame. Bus signals only matter in IDLE.
- dat_i changes after accept have no effect on the frame in flight.
- Reset mid-frame aborts: next cycle tx_o=1, state=IDLE, and any pending ack_o is cleared.
- Formal properties:
  - stall_o implies request.
  - ack_o implies accept in the previous cycle.
  - tx_o is 1 whenever state is IDLE.
  - Bit counter < CLKS_PER_BIT.
  - Bit index <= 7.

Test Plan:
- Reset: hold rst_i 3 cycles with cyc_i=stb_i=1 -> tx_o=1, ack_o=0, stall_o=0 throughout; no frame starts while reset is held.
- Single byte, CLKS_PER_BIT=4: accept 0xA5 at cycle N -> ack_o=1 only at N+1. tx_o by 4-cycle bit is 0,1,0,1,0,0,1,0,1,1 over N+1..N+40. busy_o low at N+41.
- Stall: hold request with 0x3C immediately after accepting 0xFF -> stall_o=1 for cycles N+1..N+40. 0x3C is accepted at N+41 and acked at N+42, and its start bit appears at N+42.
- Back-to-back from FIFO: stream 0x00,0x55,0xFF -> three acks spaced 41 cycles apart. Each frame is bit-exact (0x55 data bits 1,0,1,0,1,0,1,0).
- Reset mid-frame: assert rst_i during the DATA state of 0x81 -> tx_o=1 the next cycle and no ack. A later 0x0F produces a full correct frame.
- Bus qualifiers: stb_i=1 with cyc_i=0 -> no accept, stall_o=0. Dropping cyc_i mid-frame -> frame completes unchanged.
